// File: rtl/alu_md_pkg.sv
// Shared constants for the ALU control / multiply-divide block: ALU codes, ALUOp and
// funct encodings, sequencer states and the combinational decode helpers.
package alu_md_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_PASS = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_OR    = 3'b011;
  localparam logic [2:0] AOP_SLT   = 3'b100;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  // mult/multu/div/divu share this prefix; bit 1 selects divide, bit 0 unsigned
  localparam logic [3:0] FN_MD_PREFIX = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_funct(input logic [5:0] fn);
    return fn[5:2] == FN_MD_PREFIX;
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MFLO);
  endfunction

  function automatic logic [3:0] funct_decode(input logic [5:0] fn);
    logic [3:0] code;
    case (fn)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_XOR:  code = ALU_XOR;
      FN_NOR:  code = ALU_NOR;
      FN_SLT:  code = ALU_SLT;
      FN_SLL:  code = ALU_SLL;
      FN_SRL:  code = ALU_SRL;
      FN_MFHI: code = ALU_PASS;
      FN_MFLO: code = ALU_PASS;
      default: code = ALU_NOP;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] alu_decode(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] code;
    case (op)
      AOP_ADD:   code = ALU_ADD;
      AOP_SUB:   code = ALU_SUB;
      AOP_OR:    code = ALU_OR;
      AOP_SLT:   code = ALU_SLT;
      AOP_RTYPE: code = funct_decode(fn);
      default:   code = ALU_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// Decode/issue bus between the control unit and alu_md_control.
interface alu_md_control_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  // issue is a single-cycle request sampled on the rising clock; if stall is high in
  // that same cycle the request was dropped and must be presented again. md_done
  // pulses for one cycle each time HI/LO take a finished result.
  logic [2:0]        alu_op;
  logic [5:0]        func;
  logic              issue;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [CTRL_W-1:0] alu_control;
  logic              md_busy;
  logic              md_done;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output alu_op, func, issue, src_a, src_b,
    input  alu_control, md_busy, md_done, stall, hi, lo
  );

  modport slave (
    input  alu_op, func, issue, src_a, src_b,
    output alu_control, md_busy, md_done, stall, hi, lo
  );
endinterface

// File: rtl/alu_md_control_md_step.sv
// One iteration of the multiply/divide sequencer: shift-add for multiply,
// restoring shift-subtract for divide.
module md_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, hi_in} + {1'b0, opnd};
    rem_sh = {hi_in, lo_in[DATA_W-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // Remainder stays below the divisor, so diff's top bit is a clean borrow flag
      if (!diff[DATA_W]) begin
        hi_out = diff[DATA_W-1:0];
        lo_out = {lo_in[DATA_W-2:0], 1'b1};
      end else begin
        hi_out = rem_sh[DATA_W-1:0];
        lo_out = {lo_in[DATA_W-2:0], 1'b0};
      end
    end else if (lo_in[0]) begin
      {hi_out, lo_out} = {sum, lo_in[DATA_W-1:1]};
    end else begin
      {hi_out, lo_out} = {1'b0, hi_in, lo_in[DATA_W-1:1]};
    end
  end
endmodule

// File: rtl/alu_md_control.sv
// ALU control decode plus iterative mult/multu/div/divu sequencer with HI/LO.
// Define SIGNED_MD_EN to make mult/div signed; otherwise all four run unsigned.
module alu_md_control
  import alu_md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_md_control_if.slave     bus,
  output md_state_e           dbg_state
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              md_req, hilo_req, busy, accept, step_div;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] res_hi, res_lo;

  assign md_req   = (bus.alu_op == AOP_RTYPE) && is_md_funct(bus.func);
  assign hilo_req = (bus.alu_op == AOP_RTYPE) && is_hilo_funct(bus.func);
  assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign accept   = bus.issue && md_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign step_div = (state_q == ST_DIV);

  md_step #(.DATA_W(DATA_W)) u_step (
    .is_div (step_div),
    .hi_in  (acc_hi_q),
    .lo_in  (acc_lo_q),
    .opnd   (opnd_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

`ifdef SIGNED_MD_EN
  logic signed_op;
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;

  assign signed_op = ~bus.func[0];
  assign mag_a = (signed_op && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (signed_op && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

  // A zero divisor keeps the all-ones quotient; the remainder sign restores the dividend
  always_comb begin
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_res_d = signed_op && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]) && (bus.src_b != '0);
      neg_rem_d = signed_op && bus.src_a[DATA_W-1];
    end
  end

  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
    if (state_q == ST_MUL) begin
      if (neg_res_q) {res_hi, res_lo} = -{step_hi, step_lo};
    end else begin
      if (neg_res_q) res_lo = -step_lo;
      if (neg_rem_q) res_hi = -step_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign mag_a  = bus.src_a;
  assign mag_b  = bus.src_b;
  assign res_hi = step_hi;
  assign res_lo = step_lo;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_MUL, ST_DIV: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase
    // Multiply iterates over the multiplier in LO; divide shifts the dividend out of LO
    if (accept) begin
      state_d  = bus.func[1] ? ST_DIV : ST_MUL;
      cnt_d    = '0;
      acc_hi_d = '0;
      acc_lo_d = bus.func[1] ? mag_a : mag_b;
      opnd_d   = bus.func[1] ? mag_b : mag_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.alu_control = CTRL_W'(alu_decode(bus.alu_op, bus.func));
  assign bus.md_busy     = busy;
  assign bus.md_done     = (state_q == ST_DONE);
  assign bus.stall       = bus.issue && (md_req || hilo_req) && busy;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_md_control.sv
// Bench for alu_md_control: decode table, directed mult/div corner cases, and random
// back-to-back operations checked against an arithmetic model (honours SIGNED_MD_EN).
module tb_alu_md_control;
  import alu_md_pkg::*;

  localparam int DW = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;

  logic      clk;
  logic      rst_n;
  md_state_e dbg_state;
  int        n_checks;
  int        n_fail;

  alu_md_control_if #(.DATA_W(DW), .CTRL_W(4)) bus ();

  alu_md_control #(.DATA_W(DW), .CTRL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: the arithmetic meaning of each MD funct
  function automatic void model(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                output logic [DW-1:0] ehi, output logic [DW-1:0] elo);
    logic        sgn;
    logic [63:0] p;
    longint      q;
    longint      r;
    sgn = 1'b0;
`ifdef SIGNED_MD_EN
    sgn = ~fn[0];
`endif
    if (!fn[1]) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'b0, a} * {32'b0, b};
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == '0) begin
      ehi = a;
      elo = '1;
    end else if (sgn) begin
      q   = longint'($signed(a)) / longint'($signed(b));
      r   = longint'($signed(a)) % longint'($signed(b));
      ehi = r[31:0];
      elo = q[31:0];
    end else begin
      ehi = a % b;
      elo = a / b;
    end
  endfunction

  // driver: call at a negedge; returns at the negedge where md_done is seen (or budget out)
  task automatic run_md(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [DW-1:0] hi_o, output logic [DW-1:0] lo_o,
                        output int cyc, output int busy_n);
    bus.issue  = 1'b1;
    bus.alu_op = 3'b010;
    bus.func   = fn;
    bus.src_a  = a;
    bus.src_b  = b;
    @(negedge clk);
    bus.issue = 1'b0;
    cyc    = 0;
    busy_n = 0;
    while (cyc < 100) begin
      cyc++;
      if (bus.md_busy) busy_n++;
      if (bus.md_done) break;
      @(negedge clk);
    end
    hi_o = bus.hi;
    lo_o = bus.lo;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_vec_t;

  dec_vec_t dec_tab[$];

  initial begin : main
    logic [DW-1:0] hi_v, lo_v, ehi, elo, a, b;
    logic [5:0]    fn;
    logic [DW-1:0] exp_q[$];
    int            cyc, busy_n, stall_n, stall_at_done;
    logic [5:0]    md_fns[4];

    n_checks = 0;
    n_fail   = 0;
    md_fns[0] = F_MULT;  md_fns[1] = F_MULTU;
    md_fns[2] = F_DIV;   md_fns[3] = F_DIVU;

    rst_n      = 1'b0;
    bus.issue  = 1'b0;
    bus.alu_op = 3'b000;
    bus.func   = 6'b0;
    bus.src_a  = '0;
    bus.src_b  = '0;

    // reset state
    #12;
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_flags", {61'b0, bus.md_busy, bus.md_done, bus.stall}, 64'd0);

    // decode table
    dec_tab = '{
      '{3'b000, 6'b101010, 4'b0010}, '{3'b001, 6'b100000, 4'b0110},
      '{3'b011, 6'b000000, 4'b0001}, '{3'b100, 6'b100111, 4'b0111},
      '{3'b101, 6'b100000, 4'b1111}, '{3'b110, 6'b100000, 4'b1111},
      '{3'b111, 6'b100000, 4'b1111}, '{3'b010, 6'b100000, 4'b0010},
      '{3'b010, 6'b100010, 4'b0110}, '{3'b010, 6'b100100, 4'b0000},
      '{3'b010, 6'b100101, 4'b0001}, '{3'b010, 6'b100110, 4'b0011},
      '{3'b010, 6'b100111, 4'b1100}, '{3'b010, 6'b101010, 4'b0111},
      '{3'b010, 6'b000000, 4'b1000}, '{3'b010, 6'b000010, 4'b1001},
      '{3'b010, 6'b010000, 4'b1110}, '{3'b010, 6'b010010, 4'b1110},
      '{3'b010, 6'b011000, 4'b1111}, '{3'b010, 6'b011011, 4'b1111},
      '{3'b010, 6'b111111, 4'b1111}, '{3'b010, 6'b000011, 4'b1111}
    };
    foreach (dec_tab[i]) begin
      bus.alu_op = dec_tab[i].op;
      bus.func   = dec_tab[i].fn;
      #1;
      check($sformatf("decode_%0d op=%b fn=%b", i, dec_tab[i].op, dec_tab[i].fn),
            64'(bus.alu_control), 64'(dec_tab[i].exp));
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // multu 7*6: latency and busy length
    run_md(F_MULTU, 32'd7, 32'd6, hi_v, lo_v, cyc, busy_n);
    check("multu_latency", 64'(cyc), 64'(DW + 1));
    check("multu_busy_cycles", 64'(busy_n), 64'(DW));
    check("multu_lo", 64'(lo_v), 64'd42);
    check("multu_hi", 64'(hi_v), 64'd0);
    @(negedge clk);
    check("done_pulse_one_cycle", {62'b0, bus.md_done, bus.md_busy}, 64'd0);
    check("back_to_idle", 64'(dbg_state), 64'(ST_IDLE));

    // mult 0xFFFFFFFD * 5
    run_md(F_MULT, 32'hFFFF_FFFD, 32'd5, hi_v, lo_v, cyc, busy_n);
`ifdef SIGNED_MD_EN
    check("mult_neg_hi", 64'(hi_v), 64'hFFFF_FFFF);
`else
    check("mult_neg_hi", 64'(hi_v), 64'd4);
`endif
    check("mult_neg_lo", 64'(lo_v), 64'hFFFF_FFF1);

    // divu 100/7, issued straight from DONE
    run_md(F_DIVU, 32'd100, 32'd7, hi_v, lo_v, cyc, busy_n);
    check("divu_lo", 64'(lo_v), 64'd14);
    check("divu_hi", 64'(hi_v), 64'd2);

    // div -100/7
    run_md(F_DIV, 32'hFFFF_FF9C, 32'd7, hi_v, lo_v, cyc, busy_n);
`ifdef SIGNED_MD_EN
    check("div_neg_lo", 64'(lo_v), 64'hFFFF_FFF2);
    check("div_neg_hi", 64'(hi_v), 64'hFFFF_FFFE);
`else
    check("div_neg_lo", 64'(lo_v), 64'h2492_4916);
    check("div_neg_hi", 64'(hi_v), 64'd2);
`endif

    // divu 55/0 with mfhi held on issue for the whole operation
    bus.issue  = 1'b1;
    bus.alu_op = 3'b010;
    bus.func   = F_DIVU;
    bus.src_a  = 32'd55;
    bus.src_b  = 32'd0;
    @(negedge clk);
    bus.func      = F_MFHI;
    cyc           = 0;
    stall_n       = 0;
    stall_at_done = 1;
    while (cyc < 100) begin
      cyc++;
      if (bus.md_busy && bus.stall) stall_n++;
      if (bus.md_done) begin
        stall_at_done = int'(bus.stall);
        break;
      end
      @(negedge clk);
    end
    check("mfhi_stall_cycles", 64'(stall_n), 64'(DW));
    check("mfhi_no_stall_in_done", 64'(stall_at_done), 64'd0);
    check("divu_zero_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("divu_zero_hi", 64'(bus.hi), 64'd55);
    bus.issue = 1'b0;
    @(negedge clk);

    // reset in the middle of a mult
    bus.issue  = 1'b1;
    bus.alu_op = 3'b010;
    bus.func   = F_MULT;
    bus.src_a  = 32'h0001_2345;
    bus.src_b  = 32'h0000_6789;
    @(negedge clk);
    bus.issue = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.md_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_md(F_MULT, 32'h0001_2345, 32'h0000_6789, hi_v, lo_v, cyc, busy_n);
    model(F_MULT, 32'h0001_2345, 32'h0000_6789, ehi, elo);
    check("post_reset_mult_hi", 64'(hi_v), 64'(ehi));
    check("post_reset_mult_lo", 64'(lo_v), 64'(elo));

    // random back-to-back operations against the model
    for (int i = 0; i < 16; i++) begin
      fn = md_fns[$urandom_range(0, 3)];
      a  = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
      model(fn, a, b, ehi, elo);
      exp_q.push_back(ehi);
      exp_q.push_back(elo);
      run_md(fn, a, b, hi_v, lo_v, cyc, busy_n);
      check($sformatf("rand_%0d_hi fn=%b a=%h b=%h", i, fn, a, b), 64'(hi_v), 64'(exp_q.pop_front()));
      check($sformatf("rand_%0d_lo fn=%b a=%h b=%h", i, fn, a, b), 64'(lo_v), 64'(exp_q.pop_front()));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
